// File: rtl/seven_seg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : seven_seg_pkg                                                 |
// | Purpose  : Constants and helpers shared by the seven-segment decoder and |
// |            the scanned-display blocks that feed it.                      |
// | Contents : NIB_W       - nibble width (decoder inputs x3..x0)            |
// |            MAX_DIGITS  - widest digit vector the helper accepts          |
// |            nib_select  - pick nibble 'sel' out of a packed digit vector  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package seven_seg_pkg;

  localparam int NIB_W      = 4;
  localparam int MAX_DIGITS = 16;
  localparam int NIB_VEC_W  = NIB_W * MAX_DIGITS;

  // Narrower digit vectors are zero-extended by the caller to NIB_VEC_W so a
  // single fixed-width helper serves every display size.
  function automatic logic [NIB_W-1:0] nib_select(
    input logic [NIB_VEC_W-1:0] vec,
    input int unsigned          sel
  );
    return vec[sel*NIB_W +: NIB_W];
  endfunction

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tick_gen                                                      |
// | Purpose  : Free-running prescaler; pulses 'tick' once every PRESCALE     |
// |            clock cycles (every cycle when PRESCALE = 1).                 |
// | Ports    : clk   - clock, rising edge                                    |
// |            rst_n - asynchronous active-low reset                         |
// |            tick  - high on the last cycle of each PRESCALE period        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  // Keep at least one counter bit so PRESCALE = 1 still elaborates cleanly;
  // the counter then simply sits at zero and tick stays high.
  localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] C_PCNT_LAST = PCNT_W'(PRESCALE - 1);

  logic [PCNT_W-1:0] pcnt_q;
  logic [PCNT_W-1:0] pcnt_d;

  assign tick = (pcnt_q == C_PCNT_LAST);

  always_comb begin
    pcnt_d = pcnt_q + 1'b1;
    if (tick) begin
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule : tick_gen
`default_nettype wire

// File: rtl/hex_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hex_scan_driver                                               |
// | Purpose  : Latches a multi-digit hex value via load/ready and scans it   |
// |            one nibble per slot onto a seven-segment decoder, with        |
// |            active-low common-anode digit enables and optional            |
// |            leading-zero blanking. New values commit only at frame        |
// |            boundaries so a frame never tears.                            |
// | Ports    : clk, rst_n    - clock / async active-low reset                |
// |            load, value   - capture strobe and 4*NUM_DIGITS hex value     |
// |            blank_lz      - 1 = blank leading-zero digits                 |
// |            ready         - 1 = no commit pending                         |
// |            nib           - current digit nibble (decoder x3..x0)         |
// |            digit_sel_n   - one-hot-low digit enable, all ones = blank    |
// |            frame_start   - one-cycle pulse after the index wraps to 0    |
// | Params   : NUM_DIGITS (2..16), PRESCALE (>=1 clk per digit slot)        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module hex_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [NIB_W*NUM_DIGITS-1:0] value,
  input  logic                        blank_lz,
  output logic                        ready,
  output logic [NIB_W-1:0]            nib,
  output logic [NUM_DIGITS-1:0]       digit_sel_n,
  output logic                        frame_start
);

  localparam int DISP_W   = NIB_W * NUM_DIGITS;
  localparam int IDX_W    = $clog2(NUM_DIGITS);
  localparam int IDX_SPAN = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [IDX_W-1:0]  idx_q,         idx_d;
  logic [DISP_W-1:0] disp_q,        disp_d;
  logic [DISP_W-1:0] shadow_q,      shadow_d;
  logic              pending_q,     pending_d;
  logic              frame_start_q, frame_start_d;

  logic                 w_tick;
  logic                 w_wrap;
  logic                 w_blank;
  logic [IDX_SPAN-1:0]  w_upper_zero;
  logic [NIB_VEC_W-1:0] w_disp_ext;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_wrap = w_tick && (idx_q == C_IDX_LAST);

  always_comb begin
    idx_d         = idx_q;
    disp_d        = disp_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    frame_start_d = w_wrap;

    if (w_tick) begin
      idx_d = w_wrap ? '0 : idx_q + 1'b1;
    end

    // Commit uses the shadow as it stood before this edge, so a load landing
    // on the boundary edge is held back one full frame instead of tearing.
    if (w_wrap && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end

    // A load always wins the pending flag, including on the commit edge.
    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      disp_q        <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      disp_q        <= disp_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
    end
  end

  // w_upper_zero[i]: nibbles i..NUM_DIGITS-1 of the displayed value are all
  // zero. Padded to a power of two so indexing by idx_q is always in range.
  for (genvar gi = 0; gi < IDX_SPAN; gi++) begin : g_lz
    if (gi < NUM_DIGITS) begin : g_real
      assign w_upper_zero[gi] = ~|disp_q[DISP_W-1:NIB_W*gi];
    end else begin : g_pad
      assign w_upper_zero[gi] = 1'b0;
    end
  end

  // Digit 0 is never blanked so a zero value still shows a single "0".
  assign w_blank = blank_lz && (idx_q != '0) && w_upper_zero[idx_q];

  always_comb begin
    w_disp_ext               = '0;
    w_disp_ext[DISP_W-1:0]   = disp_q;
  end

  assign nib         = nib_select(w_disp_ext, 32'(idx_q));
  assign digit_sel_n = w_blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
  assign ready       = ~pending_q;
  assign frame_start = frame_start_q;

endmodule : hex_scan_driver
`default_nettype wire

// File: tb/tb_hex_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hex_scan_driver                                            |
// | Purpose  : Self-checking bench for hex_scan_driver (NUM_DIGITS=4,        |
// |            PRESCALE=4). A reference model predicts outputs each cycle;   |
// |            predictions are queued and compared on the falling edge.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_hex_scan_driver;

  localparam int ND = 4;
  localparam int PS = 4;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        load     = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value    = 16'h0;
  logic        ready;
  logic [3:0]  nib;
  logic [3:0]  digit_sel_n;
  logic        frame_start;

  always #5 clk = ~clk;

  hex_scan_driver #(
    .NUM_DIGITS (ND),
    .PRESCALE   (PS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .value       (value),
    .blank_lz    (blank_lz),
    .ready       (ready),
    .nib         (nib),
    .digit_sel_n (digit_sel_n),
    .frame_start (frame_start)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_pcnt;
  int          m_idx;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;
  logic        m_pending;
  logic        m_fs;
  logic        m_tick;
  logic        m_wrap;

  assign m_tick = (m_pcnt == PS - 1);
  assign m_wrap = m_tick && (m_idx == ND - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pcnt    <= 0;
      m_idx     <= 0;
      m_disp    <= 16'h0;
      m_shadow  <= 16'h0;
      m_pending <= 1'b0;
      m_fs      <= 1'b0;
    end else begin
      m_pcnt <= m_tick ? 0 : m_pcnt + 1;
      if (m_tick) m_idx <= m_wrap ? 0 : m_idx + 1;
      m_fs <= m_wrap;
      if (m_wrap && m_pending) m_disp <= m_shadow;
      if (load) begin
        m_shadow  <= value;
        m_pending <= 1'b1;
      end else if (m_wrap && m_pending) begin
        m_pending <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [3:0] nib;
    logic [3:0] sel;
    logic       rdy;
    logic       fs;
  } exp_t;

  exp_t sb[$];

  task automatic push_expected();
    exp_t e;
    logic blank;
    e.nib = m_disp[4*m_idx +: 4];
    blank = blank_lz && (m_idx != 0) && ((m_disp >> (4*m_idx)) == 16'h0);
    e.sel = blank ? 4'hF : ~(4'b0001 << m_idx);
    e.rdy = !m_pending;
    e.fs  = m_fs;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("nib",         16'(nib),         16'(e.nib));
      chk("digit_sel_n", 16'(digit_sel_n), 16'(e.sel));
      chk("ready",       16'(ready),       16'(e.rdy));
      chk("frame_start", 16'(frame_start), 16'(e.fs));
    end
  end

  // One clock: wait for the edge, apply the inputs for the next edge, and
  // queue the prediction for the state just entered.
  task automatic step(input logic ld, input logic [15:0] v, input logic blz);
    @(posedge clk);
    #1;
    load     = ld;
    value    = v;
    blank_lz = blz;
    push_expected();
  endtask

  task automatic idle(input int n, input logic blz);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, blz);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_nib"},   16'(nib),         16'h0);
    chk({tag, "_sel"},   16'(digit_sel_n), 16'hE);
    chk({tag, "_ready"}, 16'(ready),       16'h1);
    chk({tag, "_fs"},    16'(frame_start), 16'h0);
  endtask

  initial begin
    bit found;

    #1 rst_n = 1'b0;
    #1 check_reset_values("rst0");
    #1 rst_n = 1'b1;

    // Idle scan from reset: all zero, digits rotate, frame pulses.
    idle(40, 1'b0);

    // Plain load, no blanking.
    step(1'b1, 16'h12AF, 1'b0);
    idle(40, 1'b0);

    // Leading-zero blanking, then an all-zero value.
    step(1'b1, 16'h00A0, 1'b1);
    idle(40, 1'b1);
    step(1'b1, 16'h0000, 1'b1);
    idle(40, 1'b1);
    blank_lz = 1'b0;

    // Two loads in one frame: only the later one is ever displayed.
    step(1'b1, 16'h1111, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 16'h2222, 1'b0);
    idle(40, 1'b0);

    // Load landing exactly on the wrap edge while 3333 is pending.
    step(1'b1, 16'h3333, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (m_idx == ND - 1 && m_pcnt == PS - 1) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 16'h0, 1'b0);
    end
    chk("wrap_edge_found", 16'(found), 16'h1);
    load  = 1'b1;
    value = 16'h4444;
    step(1'b0, 16'h0, 1'b0);
    chk("ready_across_wrap", 16'(ready), 16'h0);
    chk("nib_after_wrap",    16'(nib),   16'h3);
    idle(40, 1'b0);

    // Asynchronous reset mid-slot with a load pending.
    step(1'b1, 16'h5555, 1'b0);
    idle(2, 1'b0);
    #5 rst_n = 1'b0;
    #1 check_reset_values("rst_mid");
    #1 rst_n = 1'b1;
    idle(40, 1'b0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 16'(sb.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_hex_scan_driver
`default_nettype wire
